// File: rtl/rca_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer driving one external 2-bit ripple-carry adder, LSB digit first.
// Optional subtract mode (A-B, two's complement) enabled by defining RCA_SUB_EN.
module rca_serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
`ifdef RCA_SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
   output logic             busy,
   output logic [1:0]       add_a,
   output logic [1:0]       add_b,
   output logic             add_cin,
   input  logic [1:0]       add_sum,
   input  logic             add_cout
);

   localparam int DIGITS = WIDTH / 2;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
         $error("rca_serial_add_ctrl: WIDTH must be even and >= 2");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry_reg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] result_shift;
   logic             b_inv;

`ifdef RCA_SUB_EN
   logic sub_reg;
   assign b_inv = sub_reg;
`else
   assign b_inv = 1'b0;
`endif

   // New sum digit enters at the MSB end; after DIGITS shifts digit 0 sits at the LSB.
   generate
      if (WIDTH == 2) begin : g_shift_w2
         assign result_shift = add_sum;
      end else begin : g_shift_wn
         assign result_shift = {add_sum, result[WIDTH-1:2]};
      end
   endgenerate

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == RUN) || (state == DONE);
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      if (state == RUN) begin
         add_a   = a_sr[1:0];
         add_b   = b_sr[1:0] ^ {2{b_inv}};
         add_cin = carry_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         carry_reg   <= 1'b0;
         cnt         <= '0;
         result      <= '0;
         result_cout <= 1'b0;
`ifdef RCA_SUB_EN
         sub_reg     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= op_a;
                  b_sr   <= op_b;
                  cnt    <= '0;
                  result <= '0;
                  state  <= RUN;
`ifdef RCA_SUB_EN
                  sub_reg   <= op_sub;
                  carry_reg <= op_sub ? 1'b1 : op_cin;
`else
                  carry_reg <= op_cin;
`endif
               end
            end
            RUN: begin
               result    <= result_shift;
               carry_reg <= add_cout;
               a_sr      <= a_sr >> 2;
               b_sr      <= b_sr >> 2;
               cnt       <= cnt + CW'(1);
               if (cnt == LAST) begin
                  result_cout <= add_cout;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// Directed bench for rca_serial_add_ctrl (WIDTH=8) with a behavioural 2-bit adder attached.
// Subtract vectors are included when RCA_SUB_EN is defined.
module tb_rca_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_cin;
   logic       op_sub;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       result_cout;
   logic       busy;
   logic [1:0] add_a;
   logic [1:0] add_b;
   logic       add_cin;
   logic [1:0] add_sum;
   logic       add_cout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // External 2-bit ripple-carry adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {2'b00, add_cin};

   rca_serial_add_ctrl #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_cin      (op_cin),
`ifdef RCA_SUB_EN
      .op_sub      (op_sub),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_cout (result_cout),
      .busy        (busy),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_cin     (add_cin),
      .add_sum     (add_sum),
      .add_cout    (add_cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " add_a"}, 32'(add_a), 32'd0);
      chk({tag, " add_b"}, 32'(add_b), 32'd0);
      chk({tag, " add_cin"}, 32'(add_cin), 32'd0);
   endtask

   // Entered at the negedge of RUN cycle 0; leaves at the negedge of the first DONE cycle.
   task automatic run_checks(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic sub, input logic [3:0] cinseq);
      logic [7:0] ash;
      logic [7:0] bsh;
      ash = a;
      bsh = b;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s c%0d add_a", tag, k), 32'(add_a), 32'(ash[1:0]));
         chk($sformatf("%s c%0d add_b", tag, k), 32'(add_b), 32'(sub ? ~bsh[1:0] : bsh[1:0]));
         chk($sformatf("%s c%0d add_cin", tag, k), 32'(add_cin), 32'(cinseq[k]));
         chk($sformatf("%s c%0d out_valid", tag, k), 32'(out_valid), 32'd0);
         chk($sformatf("%s c%0d in_ready", tag, k), 32'(in_ready), 32'd0);
         chk($sformatf("%s c%0d busy", tag, k), 32'(busy), 32'd1);
         ash = ash >> 2;
         bsh = bsh >> 2;
         @(negedge clk);
      end
      chk({tag, " done out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " done busy"}, 32'(busy), 32'd1);
      chk({tag, " done add_a"}, 32'(add_a), 32'd0);
   endtask

   task automatic start(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      op_cin   = cin;
      op_sub   = sub;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic release_done(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_idle({tag, " idle"});
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic [3:0] cinseq,
                         input logic [7:0] exp_r, input logic exp_c);
      start(a, b, cin, sub);
      run_checks(tag, a, b, sub, cinseq);
      chk({tag, " result"}, 32'(result), 32'(exp_r));
      chk({tag, " result_cout"}, 32'(result_cout), 32'(exp_c));
      release_done(tag);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_cin    = 1'b0;
      op_sub    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_idle("reset");
      chk("reset result", 32'(result), 32'd0);
      chk("reset result_cout", 32'(result_cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_idle("post-reset");

      run_op("t1", 8'h01, 8'h03, 1'b1, 1'b0, 4'b0011, 8'h05, 1'b0);
      run_op("t2", 8'hFF, 8'hFF, 1'b1, 1'b0, 4'b1111, 8'hFF, 1'b1);
      run_op("t3", 8'hFF, 8'h00, 1'b1, 1'b0, 4'b1111, 8'h00, 1'b1);

      // Backpressure with a competing request held during DONE
      start(8'h02, 8'h01, 1'b0, 1'b0);
      run_checks("t4", 8'h02, 8'h01, 1'b0, 4'b0000);
      in_valid = 1'b1;
      op_a     = 8'h44;
      op_b     = 8'h11;
      op_cin   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t4 hold%0d result", i), 32'(result), 32'h03);
         chk($sformatf("t4 hold%0d result_cout", i), 32'(result_cout), 32'd0);
         chk($sformatf("t4 hold%0d in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("t4 hold%0d busy", i), 32'(busy), 32'd1);
         chk($sformatf("t4 hold%0d out_valid", i), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t4 idle out_valid", 32'(out_valid), 32'd0);
      chk("t4 idle in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      run_checks("t4b", 8'h44, 8'h11, 1'b0, 4'b0000);
      chk("t4b result", 32'(result), 32'h55);
      chk("t4b result_cout", 32'(result_cout), 32'd0);
      release_done("t4b");

      // Reset while cnt==2
      start(8'hAA, 8'h55, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("t5 pre-rst busy", 32'(busy), 32'd1);
      chk("t5 pre-rst add_a", 32'(add_a), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("t5 after-rst");
      chk("t5 after-rst result", 32'(result), 32'd0);
      chk("t5 after-rst result_cout", 32'(result_cout), 32'd0);
      run_op("t5b", 8'h10, 8'h20, 1'b0, 1'b0, 4'b0000, 8'h30, 1'b0);

`ifdef RCA_SUB_EN
      run_op("t6a", 8'h05, 8'h07, 1'b0, 1'b1, 4'b0001, 8'hFE, 1'b0);
      run_op("t6b", 8'h07, 8'h05, 1'b0, 1'b1, 4'b1111, 8'h02, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
